// File: rtl/switch2_arbiter_if.sv
// rtl/switch2_arbiter_if.sv - requester, switch-control and status signals of one 2x2 switch element
interface switch2_arbiter_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 left_valid;
  logic                 left_dest;
  logic                 right_valid;
  logic                 right_dest;
  logic                 left_ready;
  logic                 right_ready;
  logic                 select;
  logic                 left_out_valid;
  logic                 right_out_valid;
  logic [CNT_WIDTH-1:0] conflict_count;

  modport master (
    output left_valid, left_dest, right_valid, right_dest,
    input  left_ready, right_ready, select, left_out_valid, right_out_valid, conflict_count
  );

  modport slave (
    input  left_valid, left_dest, right_valid, right_dest,
    output left_ready, right_ready, select, left_out_valid, right_out_valid, conflict_count
  );
endinterface

// File: rtl/switch2_arbiter.sv
// rtl/switch2_arbiter.sv - grant/route controller for a registered 2x2 crossbar element
// Round-robin on same-destination conflicts; output valids delayed to match switch latency.
module switch2_arbiter #(
  parameter int SWITCH_LATENCY = 2,
  parameter int CNT_WIDTH      = 16
) (
  input  logic             clk,
  input  logic             rst,
  switch2_arbiter_if.slave bus
);

  typedef enum logic {PRIO_LEFT = 1'b0, PRIO_RIGHT = 1'b1} prio_t;

  prio_t                     prio;
  logic                      sel_hold;
  logic [CNT_WIDTH-1:0]      cnt;
  logic [SWITCH_LATENCY-1:0] lo_pipe;
  logic [SWITCH_LATENCY-1:0] ro_pipe;

  logic l_rdy, r_rdy, sel, conflict;
  logic lo_flag, ro_flag;

  // Left reaches dest d with select=d, right reaches dest d with select=~d.
  always_comb begin
    l_rdy    = 1'b0;
    r_rdy    = 1'b0;
    sel      = sel_hold;
    conflict = 1'b0;
    if (rst) begin
      sel = 1'b0;
    end else if (bus.left_valid && bus.right_valid) begin
      if (bus.left_dest != bus.right_dest) begin
        l_rdy = 1'b1;
        r_rdy = 1'b1;
        sel   = bus.left_dest;
      end else begin
        conflict = 1'b1;
        if (prio == PRIO_LEFT) begin
          l_rdy = 1'b1;
          sel   = bus.left_dest;
        end else begin
          r_rdy = 1'b1;
          sel   = ~bus.right_dest;
        end
      end
    end else if (bus.left_valid) begin
      l_rdy = 1'b1;
      sel   = bus.left_dest;
    end else if (bus.right_valid) begin
      r_rdy = 1'b1;
      sel   = ~bus.right_dest;
    end
  end

  // A ready is only ever raised for a valid side, so ready alone marks a granted word.
  assign lo_flag = (l_rdy && !bus.left_dest) || (r_rdy && !bus.right_dest);
  assign ro_flag = (l_rdy &&  bus.left_dest) || (r_rdy &&  bus.right_dest);

  always_ff @(posedge clk) begin
    if (rst) begin
      prio     <= PRIO_LEFT;
      sel_hold <= 1'b0;
      cnt      <= '0;
      lo_pipe  <= '0;
      ro_pipe  <= '0;
    end else begin
      sel_hold <= sel;
      if (conflict) begin
        prio <= (prio == PRIO_LEFT) ? PRIO_RIGHT : PRIO_LEFT;
        if (cnt != {CNT_WIDTH{1'b1}}) begin
          cnt <= cnt + 1'b1;
        end
      end
      lo_pipe[0] <= lo_flag;
      ro_pipe[0] <= ro_flag;
      for (int i = 1; i < SWITCH_LATENCY; i++) begin
        lo_pipe[i] <= lo_pipe[i-1];
        ro_pipe[i] <= ro_pipe[i-1];
      end
    end
  end

  assign bus.left_ready      = l_rdy;
  assign bus.right_ready     = r_rdy;
  assign bus.select          = sel;
  assign bus.left_out_valid  = lo_pipe[SWITCH_LATENCY-1];
  assign bus.right_out_valid = ro_pipe[SWITCH_LATENCY-1];
  assign bus.conflict_count  = cnt;

endmodule
